// File: rtl/instr_uart_tx_pkg.sv
// +--------------------------------------------------------------------------+
// | instr_uart_tx_pkg : UART framing constants and FSM encoding (rev 1.0)    |
// +--------------------------------------------------------------------------+
`default_nettype none

package instr_uart_tx_pkg;

    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;
    localparam int unsigned DATA_BITS = 8;
    localparam logic [7:0]  CHAR_CR   = 8'h0D;
    localparam logic [7:0]  CHAR_LF   = 8'h0A;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        NEXT  = 3'd4
    } uart_state_e;

    // Byte 0 is the leftmost character; indices 5 and 6 are the CR/LF trailer.
    function automatic logic [7:0] msg_byte(input logic [39:0] msg, input logic [2:0] idx);
        case (idx)
            3'd0:    msg_byte = msg[39:32];
            3'd1:    msg_byte = msg[31:24];
            3'd2:    msg_byte = msg[23:16];
            3'd3:    msg_byte = msg[15:8];
            3'd4:    msg_byte = msg[7:0];
            3'd5:    msg_byte = CHAR_CR;
            default: msg_byte = CHAR_LF;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_uart_tx_baud_tick.sv
// +--------------------------------------------------------------------------+
// | instr_uart_tx_baud_tick : clearable bit-period counter (rev 1.0)         |
// +--------------------------------------------------------------------------+
`default_nettype none

module instr_uart_tx_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned      CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !clr_i && (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/instr_uart_tx.sv
// +--------------------------------------------------------------------------+
// | instr_uart_tx : 8N1 serialiser for a 5-char mnemonic plus CR/LF (rev 1.0)|
// +--------------------------------------------------------------------------+
`default_nettype none

module instr_uart_tx
    import instr_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter bit          ADD_CRLF     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] ascii,
    input  logic        send_valid,
    output logic        send_ready,
    output logic        tx,
    output logic        busy
);

    localparam logic [2:0] LAST_BYTE = ADD_CRLF ? 3'd6 : 3'd4;
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    uart_state_e state_q;
    logic [39:0] msg_q;
    logic [2:0]  byte_q;
    logic [2:0]  bit_q;
    logic        tx_q;
    logic        baud_clr;
    logic        baud_tick;
    logic [7:0]  cur_byte;

    // Holding the counter in IDLE/NEXT makes every START begin a fresh bit period.
    assign baud_clr = (state_q == IDLE) || (state_q == NEXT);
    assign cur_byte = msg_byte(msg_q, byte_q);

    instr_uart_tx_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (baud_clr),
        .tick_o (baud_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            msg_q   <= '0;
            byte_q  <= '0;
            bit_q   <= '0;
            tx_q    <= STOP_BIT;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= STOP_BIT;
                    if (send_valid) begin
                        msg_q   <= ascii;
                        byte_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= START_BIT;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        bit_q   <= '0;
                        tx_q    <= cur_byte[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (bit_q == LAST_BIT) begin
                            tx_q    <= STOP_BIT;
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= cur_byte[bit_q + 3'd1];
                        end
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    byte_q <= byte_q + 3'd1;
                    if (byte_q == LAST_BYTE) begin
                        state_q <= IDLE;
                    end else begin
                        tx_q    <= START_BIT;
                        state_q <= START;
                    end
                end
                default: begin
                    tx_q    <= STOP_BIT;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign send_ready = (state_q == IDLE);
    assign busy       = !send_ready;
    assign tx         = tx_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_uart_tx.sv
// +--------------------------------------------------------------------------+
// | tb_instr_uart_tx : scoreboarded bench over four parameter sets (rev 1.0) |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_instr_uart_tx;

    typedef struct {
        logic [7:0] d;
        int         gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rn  [4];
    logic        v   [4];
    logic [39:0] a   [4];
    logic        rdy [4];
    logic        tx  [4];
    logic        bz  [4];

    exp_t q [4][$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    instr_uart_tx #(.CLKS_PER_BIT(4), .ADD_CRLF(1'b1)) u_main (
        .clk(clk), .rst(rn[0]), .ascii(a[0]), .send_valid(v[0]),
        .send_ready(rdy[0]), .tx(tx[0]), .busy(bz[0]));
    instr_uart_tx #(.CLKS_PER_BIT(4), .ADD_CRLF(1'b0)) u_nocrlf (
        .clk(clk), .rst(rn[1]), .ascii(a[1]), .send_valid(v[1]),
        .send_ready(rdy[1]), .tx(tx[1]), .busy(bz[1]));
    instr_uart_tx #(.CLKS_PER_BIT(2), .ADD_CRLF(1'b1)) u_fast (
        .clk(clk), .rst(rn[2]), .ascii(a[2]), .send_valid(v[2]),
        .send_ready(rdy[2]), .tx(tx[2]), .busy(bz[2]));
    instr_uart_tx #(.CLKS_PER_BIT(868), .ADD_CRLF(1'b0)) u_slow (
        .clk(clk), .rst(rn[3]), .ascii(a[3]), .send_valid(v[3]),
        .send_ready(rdy[3]), .tx(tx[3]), .busy(bz[3]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a message is its 5 characters left to right, then CR LF when enabled.
    function automatic void push(input int k, input logic [39:0] m, input int nb, input int gap);
        exp_t e;
        for (int i = 0; i < nb; i++) begin
            if (i < 5)       e.d = m[39 - 8*i -: 8];
            else if (i == 5) e.d = 8'h0D;
            else             e.d = 8'h0A;
            e.gap = (i == 0) ? gap : 1;
            q[k].push_back(e);
        end
    endfunction

    task automatic smp(input int k, output logic val, inout bit ab);
        if (ab) begin
            val = 1'b1;
            return;
        end
        @(negedge clk);
        val = tx[k];
        if (rn[k] !== 1'b1) ab = 1'b1;
    endtask

    // UART receiver: every bit slot must be constant for exactly c cycles.
    task automatic mon(input int k, input int c);
        int         hi;
        logic       val;
        logic       val2;
        bit         ab;
        bit         ok;
        logic [7:0] b;
        exp_t       e;
        hi = -1;
        forever begin
            @(negedge clk);
            if (rn[k] !== 1'b1) begin
                hi = -1;
            end else if (tx[k] === 1'b1) begin
                if (hi >= 0) hi++;
            end else begin
                ab = 1'b0;
                ok = (tx[k] === 1'b0);
                for (int i = 1; i < c; i++) begin
                    smp(k, val, ab);
                    if (val !== 1'b0) ok = 1'b0;
                end
                for (int j = 0; j < 8; j++) begin
                    smp(k, val, ab);
                    b[j] = val;
                    for (int i = 1; i < c; i++) begin
                        smp(k, val2, ab);
                        if (val2 !== val) ok = 1'b0;
                    end
                end
                for (int i = 0; i < c; i++) begin
                    smp(k, val, ab);
                    if (val !== 1'b1) ok = 1'b0;
                end
                if (ab) begin
                    hi = -1;
                end else begin
                    if (q[k].size() == 0) begin
                        chk($sformatf("unexpected_frame_%0d", k), {56'd0, b}, 64'hFFFF);
                    end else begin
                        e = q[k].pop_front();
                        chk($sformatf("frame_byte_%0d", k), b, e.d);
                        chk($sformatf("frame_shape_%0d", k), ok, 1);
                        if (e.gap >= 0) chk($sformatf("frame_gap_%0d", k), hi, e.gap);
                    end
                    hi = 0;
                end
            end
        end
    endtask

    task automatic send(input int k, input int c, input int nb, input logic [39:0] m,
                        input int gap, input bit meas);
        int n;
        n = 0;
        @(negedge clk);
        while (rdy[k] !== 1'b1 && n < 100000) begin
            @(negedge clk);
            n++;
        end
        if (rdy[k] !== 1'b1) begin
            chk("ready_timeout", rdy[k], 1);
            return;
        end
        v[k] = 1'b1;
        a[k] = m;
        push(k, m, nb, gap);
        @(posedge clk);
        #1;
        chk("first_start_tx", tx[k], 0);
        chk("busy_on_accept", bz[k], 1);
        @(negedge clk);
        v[k] = 1'b0;
        a[k] = {$urandom, 8'($urandom)};
        if (meas) begin
            n = 0;
            while (bz[k] === 1'b1 && n < 100000) begin
                n++;
                @(negedge clk);
            end
            chk("busy_cycles", n, nb * (10*c + 1));
        end
    endtask

    task automatic main_seq();
        int n;
        send(0, 4, 7, 40'h4144444920, -1, 1'b1);

        // A request pulsed during frame 2 must be neither latched nor transmitted.
        fork
            send(0, 4, 7, 40'h4245512020, -1, 1'b1);
            begin
                n = 0;
                while (bz[0] !== 1'b1 && n < 1000) begin
                    @(negedge clk);
                    n++;
                end
                repeat (50) @(negedge clk);
                v[0] = 1'b1;
                a[0] = 40'h4A20202020;
                @(negedge clk);
                v[0] = 1'b0;
            end
        join

        // Back-to-back: NEXT plus one IDLE cycle separate the two messages.
        n = 0;
        @(negedge clk);
        while (rdy[0] !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        v[0] = 1'b1;
        a[0] = 40'h5357202020;
        push(0, 40'h5357202020, 7, -1);
        @(negedge clk);
        a[0] = 40'h4F52202020;
        push(0, 40'h4F52202020, 7, 2);
        n = 0;
        while (rdy[0] !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("b2b_accept", bz[0], 1);
        v[0] = 1'b0;
        n = 0;
        while (bz[0] === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end

        // Reset during bit 3 of byte 1 ('D' = 0x44, bit 3 is 0).
        send(0, 4, 7, 40'h4144442020, -1, 1'b0);
        repeat (58) @(posedge clk);
        #1;
        chk("pre_reset_tx", tx[0], 0);
        rn[0] = 1'b0;
        q[0].delete();
        #1;
        chk("reset_tx", tx[0], 1);
        chk("reset_busy", bz[0], 0);
        chk("reset_ready", rdy[0], 1);
        repeat (3) @(posedge clk);
        #1;
        rn[0] = 1'b1;
        send(0, 4, 7, 40'h5355422020, -1, 1'b1);

        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send(0, 4, 7, {$urandom, 8'($urandom)}, -1, 1'b1);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            v[k]  = 1'b0;
            a[k]  = '0;
            rn[k] = 1'b1;
        end
        #1;
        for (int k = 0; k < 4; k++) rn[k] = 1'b0;
        #2;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_tx_%0d", k), tx[k], 1);
            chk($sformatf("rst_ready_%0d", k), rdy[k], 1);
            chk($sformatf("rst_busy_%0d", k), bz[k], 0);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) rn[k] = 1'b1;

        fork
            mon(0, 4);
            mon(1, 4);
            mon(2, 2);
            mon(3, 868);
        join_none

        fork
            main_seq();
            begin
                send(1, 4, 5, 40'h4C57202020, -1, 1'b1);
                @(negedge clk);
                chk("nocrlf_ready", rdy[1], 1);
                chk("nocrlf_tx", tx[1], 1);
                send(1, 4, 5, {$urandom, 8'($urandom)}, -1, 1'b1);
            end
            begin
                send(2, 2, 7, 40'h0, -1, 1'b1);
                send(2, 2, 7, {$urandom, 8'($urandom)}, -1, 1'b1);
            end
            send(3, 868, 5, 40'h0, -1, 1'b1);
        join

        repeat (400) @(negedge clk);
        for (int k = 0; k < 4; k++) chk($sformatf("drain_%0d", k), q[k].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_uart_tx.md
INSTR_UART_TX -- requirements
Module: instr_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter ADD_CRLF, default 1; when 1, bytes 0x0D and 0x0A follow the 5 characters of each message.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 ascii  input  40  5-character instruction mnemonic from the instruction decoder; char0 = ascii[39:32] ... char4 = ascii[7:0].
REQ-006 send_valid  input  1  request to transmit the current ascii value.
REQ-007 send_ready  output  1  high when a new message can be accepted.
REQ-008 tx  output  1  UART serial line; idles high.
REQ-009 busy  output  1  high while any frame of a message is in progress.

Function
REQ-010 The block SHALL accept a message on a rising clk edge where send_valid && send_ready, latching all 40 bits of ascii into an internal message register.
REQ-011 send_ready SHALL equal 1 only in state IDLE; busy SHALL be the inverse of send_ready.
REQ-012 The FSM SHALL have the states IDLE, START, DATA, STOP and NEXT.
REQ-013 IDLE: tx=1; on accept, load byte index 0, clear the bit counter and baud counter, and go to START.
REQ-014 START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-015 DATA: send 8 bits LSB first, each held for exactly CLKS_PER_BIT cycles; after bit 7 go to STOP.
REQ-016 STOP: tx=1 for exactly CLKS_PER_BIT cycles, then go to NEXT.
REQ-017 NEXT: one cycle with tx=1; increment the byte index; if the index < N go to START, else go to IDLE. N = 7 when ADD_CRLF=1, else N = 5.
REQ-018 Each byte frame SHALL last 10*CLKS_PER_BIT cycles. Consecutive frames within a message SHALL be separated by exactly 1 extra idle-high cycle (NEXT).
REQ-019 The first start bit SHALL begin on tx in the cycle after the accepting edge; tx SHALL be a registered output.
REQ-020 Changes on ascii or send_valid while busy SHALL be ignored and SHALL NOT alter the in-flight message.
REQ-021 If send_valid is held high continuously, the next message SHALL be accepted in the IDLE cycle after the final NEXT (back-to-back, 1-cycle gap).
REQ-022 The baud counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL count from 0 to CLKS_PER_BIT-1, then wrap to 0.
REQ-023 Non-printable bytes (including 0x00) SHALL be transmitted verbatim; the block performs no filtering.

Reset
REQ-024 While rst=0, regardless of clk: state=IDLE, tx=1, send_ready=1, busy=0, and all counters and the message register cleared to 0.
REQ-025 Asserting reset mid-frame SHALL abort the message immediately with tx=1. No partial byte resumes after deassertion.
REQ-026 Reset deassertion is assumed to be synchronised to clk upstream; the first accept is possible on the first edge after deassertion.

Structure
REQ-027 The UART framing constants (START_BIT=0, STOP_BIT=1, DATA_BITS=8), the CR/LF byte values and the FSM state encoding SHALL live in a shared package/include used by future UART-based debug blocks.
REQ-028 One sub-module is natural: baud_tick, a counter parameterised by CLKS_PER_BIT that produces a 1-cycle tick and is clearable by the FSM.
REQ-029 In the top-level integration the block SHALL connect to the decoder ascii output, with send_valid driven by an instruction-change detect.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-030 Single message: ascii="ADDI " (0x4144444920), 1-cycle valid. Required response: tx shows 7 frames decoding to 41 44 44 49 20 0D 0A, each 40 cycles, with 1-cycle gaps; busy high for 7*41 cycles.
REQ-031 ADD_CRLF=0: ascii="LW   ". Required response: exactly 5 frames, then send_ready=1 and tx=1.
REQ-032 Busy-ignore: accept "BEQ  ", then pulse valid with "J    " during frame 2. Required response: only "BEQ  " plus CR/LF is transmitted; the second request is not latched.
REQ-033 Back-to-back: valid held high with "SW   " then "OR   ". Required response: the second message starts exactly 1 cycle after the first message's last NEXT.
REQ-034 Reset mid-operation: assert rst during the DATA bit 3 of byte 1. Required response: tx=1 and busy=0 at once (asynchronously). After release, a new message "SUB  " transmits correctly from byte 0.
REQ-035 Edge parameters: CLKS_PER_BIT=2 and CLKS_PER_BIT=868 with byte 0x00. Required response: a start bit plus 8 low bits plus a stop bit, with exact bit widths of 2 and 868 cycles respectively.
